// File: rtl/lj_pair_scheduler.sv
`default_nettype none
// ============================================================================
// lj_pair_scheduler : streams one reference particle against a neighbor list
// into the LJ force pipeline; results are buffered in a credit-guarded FIFO.
// Revision 1.0
// ============================================================================
module lj_pair_scheduler #(
  parameter int ADDR_W       = 12,
  parameter int NUM_W        = 16,
  parameter int PIPE_LATENCY = 24,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [31:0]       ref_x,
  input  logic [31:0]       ref_y,
  input  logic [31:0]       ref_z,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [NUM_W-1:0]  num_neighbors,
  output logic              busy,
  output logic              done,
  output logic              nb_rd_en,
  output logic [ADDR_W-1:0] nb_rd_addr,
  input  logic [95:0]       nb_rd_data,
  output logic              pipe_ivalid,
  output logic              pipe_iready,
  output logic [31:0]       pipe_ref_x,
  output logic [31:0]       pipe_ref_y,
  output logic [31:0]       pipe_ref_z,
  output logic [31:0]       pipe_nb_x,
  output logic [31:0]       pipe_nb_y,
  output logic [31:0]       pipe_nb_z,
  input  logic              pipe_ovalid,
  input  logic [127:0]      pipe_force,
  output logic              force_valid,
  output logic [127:0]      force_data,
  output logic              force_last,
  input  logic              force_ready,
  output logic              err_unexpected
);

  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_cred_w = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  // A FIFO shallower than the pipeline is legal; issue simply stalls on credits.
  if (FIFO_DEPTH < PIPE_LATENCY) begin : g_reduced_rate
  end

  logic [1:0]          state_q, state_d;
  logic [31:0]         ref_x_q, ref_y_q, ref_z_q;
  logic [ADDR_W-1:0]   base_q;
  logic [NUM_W-1:0]    num_q, issued_q, received_q, popped_q;
  logic [c_cred_w-1:0] credits_q, credits_d;
  logic                ivalid_q;
  logic                err_q;
  logic [c_ptr_w:0]    wptr_q, rptr_q;
  logic [127:0]        mem_q [FIFO_DEPTH];

  logic w_accept, w_rd, w_push, w_pop, w_empty;

  assign w_accept = (state_q == c_st_idle) && start;
  assign w_rd     = (state_q == c_st_issue) && (issued_q < num_q) && (credits_q != '0);
  assign w_empty  = (wptr_q == rptr_q);
  assign w_pop    = !w_empty && force_ready;
  assign w_push   = pipe_ovalid && (state_q != c_st_idle) && (received_q != num_q);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= c_st_idle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:  if (start) state_d = (num_neighbors == '0) ? c_st_done : c_st_issue;
      c_st_issue: if (w_rd && (issued_q + NUM_W'(1) == num_q)) state_d = c_st_drain;
      c_st_drain: if (popped_q + NUM_W'(w_pop) == num_q) state_d = c_st_done;
      c_st_done:  state_d = c_st_idle;
      default:    state_d = c_st_idle;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    nb_rd_en = 1'b0;
    case (state_q)
      c_st_issue: begin
        busy     = 1'b1;
        nb_rd_en = w_rd;
      end
      c_st_drain: busy = 1'b1;
      c_st_done:  done = 1'b1;
      default:    ;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    if (w_rd && !w_pop)      credits_d = credits_q - c_cred_w'(1);
    else if (!w_rd && w_pop) credits_d = credits_q + c_cred_w'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ref_x_q    <= '0;
      ref_y_q    <= '0;
      ref_z_q    <= '0;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      popped_q   <= '0;
      credits_q  <= c_cred_w'(FIFO_DEPTH);
      ivalid_q   <= 1'b0;
      err_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      if (w_accept) begin
        ref_x_q    <= ref_x;
        ref_y_q    <= ref_y;
        ref_z_q    <= ref_z;
        base_q     <= base_addr;
        num_q      <= num_neighbors;
        issued_q   <= '0;
        received_q <= '0;
        popped_q   <= '0;
      end else begin
        if (w_rd)   issued_q   <= issued_q + NUM_W'(1);
        if (w_push) received_q <= received_q + NUM_W'(1);
        if (w_pop)  popped_q   <= popped_q + NUM_W'(1);
      end
      credits_q <= credits_d;
      ivalid_q  <= w_rd;
      err_q     <= err_q | (pipe_ovalid & ~w_push);
      if (w_push) wptr_q <= wptr_q + (c_ptr_w + 1)'(1);
      if (w_pop)  rptr_q <= rptr_q + (c_ptr_w + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) mem_q[wptr_q[c_ptr_w-1:0]] <= pipe_force;
  end

  assign nb_rd_addr     = w_rd ? (base_q + ADDR_W'(issued_q)) : '0;
  assign pipe_ivalid    = ivalid_q;
  assign pipe_iready    = 1'b1;
  // Read data arrives one cycle after the strobe, aligned with ivalid_q.
  assign pipe_ref_x     = ivalid_q ? ref_x_q : '0;
  assign pipe_ref_y     = ivalid_q ? ref_y_q : '0;
  assign pipe_ref_z     = ivalid_q ? ref_z_q : '0;
  assign pipe_nb_x      = ivalid_q ? nb_rd_data[31:0]  : '0;
  assign pipe_nb_y      = ivalid_q ? nb_rd_data[63:32] : '0;
  assign pipe_nb_z      = ivalid_q ? nb_rd_data[95:64] : '0;
  assign force_valid    = !w_empty;
  assign force_data     = w_empty ? '0 : mem_q[rptr_q[c_ptr_w-1:0]];
  assign force_last     = !w_empty && (popped_q == num_q - NUM_W'(1));
  assign err_unexpected = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lj_pair_scheduler.sv
`default_nettype none
// Testbench for lj_pair_scheduler: memory and pipeline models plus a
// queue-based reference of the expected force stream.
`timescale 1ns/1ps
module tb_lj_pair_scheduler;
  localparam int ADDR_W = 12;
  localparam int NUM_W  = 16;
  localparam int LAT    = 24;
  localparam int DEPTH  = 32;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       ref_x = '0, ref_y = '0, ref_z = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [NUM_W-1:0]  num_neighbors = '0;
  logic              busy, done, nb_rd_en, pipe_ivalid, pipe_iready;
  logic [ADDR_W-1:0] nb_rd_addr;
  logic [95:0]       nb_rd_data = '0;
  logic [31:0]       pipe_ref_x, pipe_ref_y, pipe_ref_z, pipe_nb_x, pipe_nb_y, pipe_nb_z;
  logic              pipe_ovalid;
  logic [127:0]      pipe_force;
  logic              force_valid, force_last, err_unexpected;
  logic [127:0]      force_data;
  logic              force_ready = 1'b0;

  lj_pair_scheduler #(.ADDR_W(ADDR_W), .NUM_W(NUM_W), .PIPE_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .ref_x(ref_x), .ref_y(ref_y), .ref_z(ref_z),
    .base_addr(base_addr), .num_neighbors(num_neighbors),
    .busy(busy), .done(done), .nb_rd_en(nb_rd_en), .nb_rd_addr(nb_rd_addr),
    .nb_rd_data(nb_rd_data), .pipe_ivalid(pipe_ivalid), .pipe_iready(pipe_iready),
    .pipe_ref_x(pipe_ref_x), .pipe_ref_y(pipe_ref_y), .pipe_ref_z(pipe_ref_z),
    .pipe_nb_x(pipe_nb_x), .pipe_nb_y(pipe_nb_y), .pipe_nb_z(pipe_nb_z),
    .pipe_ovalid(pipe_ovalid), .pipe_force(pipe_force),
    .force_valid(force_valid), .force_data(force_data), .force_last(force_last),
    .force_ready(force_ready), .err_unexpected(err_unexpected)
  );

  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [127:0] fmodel(input logic [31:0] rx, input logic [31:0] ry,
                                          input logic [31:0] rz, input logic [95:0] nb);
    return {nb[95:64] ^ rx, nb[63:32] + ry, nb[31:0] - rz, rx ^ ry ^ rz ^ 32'h5A5A_0F0F};
  endfunction

  // Neighbor memory: data valid one cycle after the read strobe.
  logic [95:0] mem [4096];
  always @(posedge clock) if (nb_rd_en) nb_rd_data <= mem[nb_rd_addr];

  // Fixed-latency pipeline model, flushed by reset.
  logic         dl_v [LAT];
  logic [127:0] dl_d [LAT];
  logic         spur = 1'b0;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) dl_v[i] <= 1'b0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        dl_v[i] <= dl_v[i-1];
        dl_d[i] <= dl_d[i-1];
      end
      dl_v[0] <= pipe_ivalid;
      dl_d[0] <= fmodel(pipe_ref_x, pipe_ref_y, pipe_ref_z, {pipe_nb_z, pipe_nb_y, pipe_nb_x});
    end
  end
  assign pipe_ovalid = dl_v[LAT-1] | spur;
  assign pipe_force  = spur ? 128'hDEAD : dl_d[LAT-1];

  logic rdy_rand = 1'b0;
  always @(posedge clock) begin
    #1;
    if (rdy_rand) force_ready = 1'($urandom_range(0, 1));
  end

  // Reference state of the current run
  logic              active = 1'b0;
  logic [ADDR_W-1:0] exp_base;
  int                exp_num;
  logic [95:0]       exp_ref;
  logic [127:0]      exp_q [$];
  int rd_cnt, iv_cnt, pop_cnt, done_cnt;
  int start_cyc, done_cyc, last_pop_cyc, first_iv_cyc, last_iv_cyc;

  always @(negedge clock) begin
    if (resetn && active) begin
      if (nb_rd_en) begin
        chk("rd_addr", nb_rd_addr, ADDR_W'(exp_base + ADDR_W'(rd_cnt)));
        chk("busy_rd", busy, 1'b1);
        rd_cnt++;
      end
      if (pipe_ivalid) begin
        chk("pipe_nb", {pipe_nb_z, pipe_nb_y, pipe_nb_x}, mem[ADDR_W'(exp_base + ADDR_W'(iv_cnt))]);
        chk("pipe_ref", {pipe_ref_z, pipe_ref_y, pipe_ref_x}, exp_ref);
        if (iv_cnt == 0) first_iv_cyc = cyc;
        last_iv_cyc = cyc;
        iv_cnt++;
      end
      if (force_valid && force_ready) begin
        chk("pop_in_range", pop_cnt < exp_num, 1'b1);
        chk("force_last", force_last, pop_cnt == exp_num - 1);
        if (exp_q.size() > 0) chk("force_data", force_data, exp_q.pop_front());
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      if (done) begin
        chk("busy_at_done", busy, 1'b0);
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic launch(input logic [ADDR_W-1:0] b, input int n,
                        input logic [31:0] rx, input logic [31:0] ry, input logic [31:0] rz);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(fmodel(rx, ry, rz, mem[ADDR_W'(b + ADDR_W'(i))]));
    exp_base = b; exp_num = n; exp_ref = {rz, ry, rx};
    rd_cnt = 0; iv_cnt = 0; pop_cnt = 0; done_cnt = 0;
    @(posedge clock); #1;
    active = 1'b1;
    start = 1'b1; base_addr = b; num_neighbors = NUM_W'(n);
    ref_x = rx; ref_y = ry; ref_z = rz;
    start_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    int bound = 300 + 40 * exp_num;
    while (done_cnt == 0 && k < bound) begin
      @(negedge clock);
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt != 0, 1'b1);
    repeat (3) @(negedge clock);
    chk({tag, "_reads"}, rd_cnt, exp_num);
    chk({tag, "_ivalids"}, iv_cnt, exp_num);
    chk({tag, "_pops"}, pop_cnt, exp_num);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    if (exp_num == 0) chk({tag, "_done_lat"}, done_cyc - start_cyc, 1);
    else              chk({tag, "_done_lat"}, done_cyc - last_pop_cyc, 1);
    chk({tag, "_idle_valid"}, force_valid, 1'b0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err_unexpected, 1'b0);
    active = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rd_en"}, nb_rd_en, 1'b0);
    chk({tag, "_ivalid"}, pipe_ivalid, 1'b0);
    chk({tag, "_iready"}, pipe_iready, 1'b1);
    chk({tag, "_fvalid"}, force_valid, 1'b0);
    chk({tag, "_fdata"}, force_data, 128'h0);
    chk({tag, "_flast"}, force_last, 1'b0);
    chk({tag, "_err"}, err_unexpected, 1'b0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom};
    mem[0] = {32'h40A00000, 32'h40400000, 32'h40000000};
    mem[1] = {32'h40800000, 32'h40800000, 32'h40800000};
    mem[2] = {32'h41100000, 32'h40A00000, 32'h40000000};

    repeat (3) @(negedge clock);
    chk_reset_outputs("rst");
    @(posedge clock); #1 resetn = 1'b1;
    @(negedge clock);
    chk_reset_outputs("post_rst");

    // Basic run
    force_ready = 1'b1;
    launch(12'h000, 3, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    wait_done("basic");
    chk("basic_iv_consec", last_iv_cyc - first_iv_cyc, 2);

    // Zero count
    launch(12'h123, 0, $urandom, $urandom, $urandom);
    wait_done("zero");

    // Address wrap
    launch(12'hFFE, 4, $urandom, $urandom, $urandom);
    wait_done("wrap");

    // Backpressure: credits limit outstanding reads to the FIFO depth
    force_ready = 1'b0;
    launch(ADDR_W'($urandom), 40, $urandom, $urandom, $urandom);
    repeat (150) @(negedge clock);
    chk("bp_reads_held", rd_cnt, DEPTH);
    chk("bp_rd_en_low", nb_rd_en, 1'b0);
    @(posedge clock); #1 force_ready = 1'b1;
    wait_done("bp");

    // Start while busy must be ignored
    launch(ADDR_W'($urandom), 20, $urandom, $urandom, $urandom);
    repeat (5) @(posedge clock);
    #1 start = 1'b1; num_neighbors = 16'd7; base_addr = 12'h000;
    @(posedge clock); #1 start = 1'b0;
    wait_done("restart");

    // Randomized runs with random backpressure
    rdy_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      launch(ADDR_W'($urandom), $urandom_range(1, 70), $urandom, $urandom, $urandom);
      wait_done("rand");
    end
    rdy_rand = 1'b0;

    // Reset mid-drain
    force_ready = 1'b0;
    launch(ADDR_W'($urandom), 10, $urandom, $urandom, $urandom);
    k = 0;
    while (rd_cnt < 10 && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("drain_reads", rd_cnt, 10);
    repeat (30) @(negedge clock);
    chk("drain_fifo_filled", force_valid, 1'b1);
    chk("drain_busy", busy, 1'b1);
    @(posedge clock); #1;
    active = 1'b0;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    repeat (40) @(negedge clock);
    chk("post_rst_no_done", done, 1'b0);
    chk("post_rst_fvalid", force_valid, 1'b0);

    // Spurious result in IDLE
    @(posedge clock); #1 spur = 1'b1;
    @(posedge clock); #1 spur = 1'b0;
    @(negedge clock);
    chk("spur_err", err_unexpected, 1'b1);
    chk("spur_fvalid", force_valid, 1'b0);
    repeat (5) @(negedge clock);
    chk("spur_err_sticky", err_unexpected, 1'b1);
    chk("spur_fvalid_later", force_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
